// File: rtl/tt_um_array_multiplier_hhrb98_pkg.sv
// Shared constants and the partial-product array type for the 4x4 array multiplier.
package tt_um_array_multiplier_hhrb98_pkg;

    localparam int OPW = 4;
    localparam int PW  = 8;

    // pp[i][j] = multiplicand bit j AND multiplier bit i; row i carries weight 2**i
    typedef logic [OPW-1:0][OPW-1:0] pp_array_t;

endpackage

// File: rtl/array_mult_fa.sv
// One-bit full adder cell; half-adder cells tie cin to 0.
module array_mult_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ab_x;

    assign ab_x = a ^ b;
    assign s    = ab_x ^ cin;
    assign cout = (a & b) | (cin & ab_x);

endmodule

// File: rtl/tt_um_array_multiplier_hhrb98.sv
// Registered 4x4 unsigned array multiplier. Define MULT_INPUT_REG_EN to add an
// operand register stage ahead of the array (latency 2 instead of 1).
module tt_um_array_multiplier_hhrb98
    import tt_um_array_multiplier_hhrb98_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic [PW-1:0] ui_in,
    input  logic [PW-1:0] uio_in,
    output logic [PW-1:0] uo_out,
    output logic [PW-1:0] uio_out,
    output logic [PW-1:0] uio_oe
);

    logic [OPW-1:0] opnd_a;
    logic [OPW-1:0] opnd_b;
    logic           stage_vld;
    pp_array_t      pp;
    logic [PW-1:0]  prod;
    logic [PW-1:0]  prod_q;
    logic           valid_q;

`ifdef MULT_INPUT_REG_EN
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            opnd_a    <= '0;
            opnd_b    <= '0;
            stage_vld <= 1'b0;
        end else if (ena) begin
            opnd_a    <= ui_in[OPW-1:0];
            opnd_b    <= ui_in[PW-1:OPW];
            stage_vld <= 1'b1;
        end
    end
`else
    assign opnd_a    = ui_in[OPW-1:0];
    assign opnd_b    = ui_in[PW-1:OPW];
    assign stage_vld = 1'b1;
`endif

    for (genvar i = 0; i < OPW; i++) begin : g_pp_row
        for (genvar j = 0; j < OPW; j++) begin : g_pp_col
            assign pp[i][j] = opnd_a[j] & opnd_b[i];
        end
    end

    assign prod[0] = pp[0][0];

    // Each row adds the next partial product to the running sum shifted right by one;
    // the row's LSB retires as a product bit, the rest (with carry-out) feeds the next row.
    for (genvar r = 1; r < OPW; r++) begin : g_row
        logic [OPW-1:0] acc_in;
        logic [OPW-1:0] acc_out;

        if (r == 1) begin : g_first
            assign acc_in = {1'b0, pp[0][OPW-1:1]};
        end else begin : g_next
            assign acc_in = g_row[r-1].acc_out;
        end

        for (genvar c = 0; c < OPW; c++) begin : g_col
            logic cin;
            logic s;
            logic cout;

            if (c == 0) begin : g_ha
                assign cin = 1'b0;
            end else begin : g_fa
                assign cin = g_col[c-1].cout;
            end

            array_mult_fa u_fa (
                .a    (pp[r][c]),
                .b    (acc_in[c]),
                .cin  (cin),
                .s    (s),
                .cout (cout)
            );

            if (c == 0) begin : g_lsb
                assign prod[r] = s;
            end else begin : g_acc
                assign acc_out[c-1] = s;
            end
        end

        assign acc_out[OPW-1] = g_col[OPW-1].cout;
    end

    assign prod[PW-1:OPW] = g_row[OPW-1].acc_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q  <= '0;
            valid_q <= 1'b0;
        end else if (ena) begin
            prod_q  <= prod;
            valid_q <= stage_vld;
        end
    end

    assign uo_out  = prod_q;
    assign uio_out = {7'b0, valid_q};
    assign uio_oe  = 8'h01;

    logic unused_uio;
    assign unused_uio = &{1'b0, uio_in};

endmodule

// File: tb/tb_tt_um_array_multiplier_hhrb98.sv
// Self-checking bench: directed and random operands against a latency-queue product model.
module tb_tt_um_array_multiplier_hhrb98;

`ifdef MULT_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    // Model: queue of the last LAT operand bytes accepted; pipe[0] is the one now on uo_out.
    logic [7:0] pipe[$];
    int         since_rst = 0;

    tt_um_array_multiplier_hhrb98 dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] ref_prod(input logic [7:0] v);
        return 8'(int'(v[3:0]) * int'(v[7:4]));
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [7:0] u);
        logic exp_vld;
        rst    = r;
        ena    = e;
        ui_in  = u;
        uio_in = 8'($urandom);
        @(posedge clk);
        if (r) begin
            pipe.delete();
            repeat (LAT) pipe.push_back(8'h00);
            since_rst = 0;
        end else if (e) begin
            pipe.push_back(u);
            void'(pipe.pop_front());
            since_rst++;
        end
        #1;
        exp_vld = (since_rst >= LAT);
        check("product", uo_out, ref_prod(pipe[0]));
        check("valid", uio_out, {7'b0, exp_vld});
    endtask

    logic [7:0] bnd_in  [4] = '{8'hFF, 8'h0F, 8'hF0, 8'h11};
    logic [7:0] bnd_exp [4] = '{8'hE1, 8'h00, 8'h00, 8'h01};

    initial begin
        rst    = 1'b1;
        ena    = 1'b0;
        ui_in  = 8'hFF;
        uio_in = 8'h00;

        step(1'b1, 1'b1, 8'hFF);
        step(1'b1, 1'b0, 8'hFF);
        check("reset_out", uo_out, 8'h00);
        check("reset_valid", {7'b0, uio_out[0]}, 8'h00);
        check("uio_oe", uio_oe, 8'h01);

        repeat (LAT) step(1'b0, 1'b1, 8'h53);
        check("basic_3x5", uo_out, 8'h0F);
        check("basic_valid", {7'b0, uio_out[0]}, 8'h01);

        for (int k = 0; k < 4; k++) begin
            repeat (LAT) step(1'b0, 1'b1, bnd_in[k]);
            check($sformatf("boundary_%h", bnd_in[k]), uo_out, bnd_exp[k]);
        end

        for (int i = 0; i < 256; i++) step(1'b0, 1'b1, i[7:0]);

        repeat (LAT) step(1'b0, 1'b1, 8'h77);
        check("hold_pre", uo_out, 8'h31);
        repeat (3) step(1'b0, 1'b0, 8'h22);
        check("hold_disabled", uo_out, 8'h31);
        ui_in = 8'($urandom);
        #2;
        check("hold_glitch", uo_out, 8'h31);
        repeat (LAT) step(1'b0, 1'b1, 8'h22);
        check("hold_resume", uo_out, 8'h04);

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
        end

        repeat (5) step(1'b0, 1'b1, 8'($urandom));
        step(1'b1, 1'b1, 8'($urandom));
        check("midreset_out", uo_out, 8'h00);
        check("midreset_valid", {7'b0, uio_out[0]}, 8'h00);
        repeat (LAT) step(1'b0, 1'b1, 8'hA5);
        check("post_reset_prod", uo_out, 8'h32);
        check("post_reset_valid", {7'b0, uio_out[0]}, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_um_array_multiplier_hhrb98.md
TT_UM_ARRAY_MULTIPLIER_HHRB98 -- requirements
Module: tt_um_array_multiplier_hhrb98

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset, sampled on clk rising edge.
REQ-004 ena  input  1  clock enable; state updates only when high.
REQ-005 ui_in  input  8  operands: ui_in[3:0] = multiplicand A, ui_in[7:4] = multiplier B, both unsigned.
REQ-006 uio_in  input  8  unused; SHALL be ignored.
REQ-007 uo_out  output  8  registered unsigned product P = A*B.
REQ-008 uio_out  output  8  bit 0 = product-valid flag; bits 7:1 tied 0.
REQ-009 uio_oe  output  8  constant 8'h01 (bit 0 driven, rest input).
REQ-010 No parameters; operand width fixed at 4 bits, product width 8 bits.

Function
REQ-011 Product SHALL be computed by a 4x4 unsigned array multiplier: 16 AND partial products summed by rows of full/half adders, with no behavioural '*' operator.
REQ-012 Array SHALL be combinational from its operand source to the product register.
REQ-013 Default build (macro undefined): operands taken directly from ui_in; uo_out SHALL equal A*B of the ui_in value sampled at the previous enabled clk edge (latency 1).
REQ-014 Product SHALL be exact over the full range, 0..225, with no truncation or overflow; 15*15 = 8'hE1.
REQ-015 When ena is low, uo_out, the valid flag and any operand registers SHALL hold their values.
REQ-016 Valid flag SHALL rise at the first enabled edge after reset once the pipeline holds a real product (edge 1 default; edge 2 with REQ-021), then stay high until reset.
REQ-017 ui_in changes between edges SHALL have no effect on uo_out until the next enabled edge.

Reset
REQ-018 While rst is high at a clk edge, uo_out SHALL become 8'h00 and the valid flag 0, regardless of ena.
REQ-019 Any operand pipeline registers SHALL reset to 0.
REQ-020 Reset asserted mid-operation SHALL discard in-flight products; the first post-reset product SHALL reflect only operands sampled after reset deassertion.

Configuration
REQ-021 Macro MULT_INPUT_REG_EN: when defined, an operand register stage SHALL capture ui_in before the array, giving uo_out latency 2 enabled edges and valid rising on the 2nd enabled edge after reset. When undefined, there is no input register and latency is 1 (REQ-013).

Structure
REQ-022 A shared package SHALL hold the constants OPW = 4 and PW = 8 and the partial-product array typedef.
REQ-023 One sub-module, array_mult_fa (1-bit full adder: a, b, cin -> s, cout), SHALL be instantiated for every adder cell; half adders are full adders with cin = 0.
REQ-024 The top level SHALL contain only the operand/product registers, the valid flag, the array generate loops and the tie-offs.

Verification
REQ-025 Reset: hold rst high for 2 edges with ui_in = 8'hFF -> uo_out = 8'h00 and uio_out[0] = 0.
REQ-026 Basic product: A = 3, B = 5 (ui_in = 8'h53), ena = 1 -> uo_out = 8'h0F after 1 edge (2 edges with MULT_INPUT_REG_EN) and uio_out[0] = 1.
REQ-027 Boundaries: ui_in = 8'hFF -> 8'hE1; ui_in = 8'h0F -> 8'h00; ui_in = 8'hF0 -> 8'h00; ui_in = 8'h11 -> 8'h01.
REQ-028 Exhaustive: all 256 ui_in values applied back-to-back -> each uo_out equals the product of the value applied 1 (or 2) enabled edges earlier.
REQ-029 Hold: drive ui_in = 8'h77 (product 8'h31), then set ena = 0 and ui_in = 8'h22 -> uo_out stays 8'h31; re-enable -> 8'h04 after the configured latency.
REQ-030 Reset mid-stream: stream products, assert rst for 1 edge -> uo_out = 8'h00 and valid = 0; on release the next product is correct and valid rises per REQ-016.
